// File: rtl/zoe_digit_pkg.sv
// Shared types and helpers for the zoe digit source: FSM encoding, direction
// constants and the wrap-aware advance function.
package zoe_digit_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Returns {wrapped, next_digit} for one step in the given direction.
  function automatic logic [DIGIT_W:0] advance(input logic [DIGIT_W-1:0] d,
                                               input logic               dir,
                                               input logic [DIGIT_W-1:0] last);
    if (dir == DIR_UP)
      return (d == last) ? {1'b1, {DIGIT_W{1'b0}}} : {1'b0, d + DIGIT_W'(1)};
    else
      return (d == '0) ? {1'b1, last} : {1'b0, d - DIGIT_W'(1)};
  endfunction

endpackage

// File: rtl/zoe_debounce.sv
// Step-button conditioner: 2-flop synchroniser, stable-count filter and a
// rising-edge detector producing a one-cycle step_pulse.
module zoe_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_btn,
  output logic step_pulse
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [1:0]    sync;
  logic          step_s;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  assign step_s = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], step_btn};
      level_q <= level;
      // Any sample agreeing with the current level restarts the stability count.
      if (step_s == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        level <= step_s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign step_pulse = level & ~level_q;

endmodule

// File: rtl/zoe_digit_source.sv
// Digit generator feeding the seven-segment decoder: hold/step or free-run a
// digit in 0..LAST with load override, registered tick and wrap flags.
module zoe_digit_source
  import zoe_digit_pkg::*;
#(
  parameter int MAX_COUNT = 1000,
  parameter int DEBOUNCE  = 4,
  parameter int LAST      = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               dir,
  input  logic               step_btn,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] digit,
  output logic               tick,
  output logic               wrap
);

  localparam int                 PW     = $clog2(MAX_COUNT);
  localparam logic [DIGIT_W-1:0] LAST_D = DIGIT_W'(LAST);

  logic [1:0]              run_sync, dir_sync, load_sync;
  logic [1:0][DIGIT_W-1:0] lv_sync;
  logic                    run_s, dir_s, load_s;
  logic [DIGIT_W-1:0]      lv_s, lv_clamp;
  logic                    step_pulse;

  state_e                  state, state_nxt;
  logic [PW-1:0]           presc, presc_nxt;
  logic                    expire, adv;
  logic [DIGIT_W:0]        adv_res;

  zoe_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_btn   (step_btn),
    .step_pulse (step_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_sync  <= '0;
      dir_sync  <= '0;
      load_sync <= '0;
      lv_sync   <= '0;
    end else begin
      run_sync  <= {run_sync[0], run};
      dir_sync  <= {dir_sync[0], dir};
      load_sync <= {load_sync[0], load};
      lv_sync   <= {lv_sync[0], load_val};
    end
  end

  assign run_s    = run_sync[1];
  assign dir_s    = dir_sync[1];
  assign load_s   = load_sync[1];
  assign lv_s     = lv_sync[1];
  assign lv_clamp = (lv_s > LAST_D) ? LAST_D : lv_s;

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    expire    = 1'b0;
    adv       = 1'b0;
    unique case (state)
      ST_HOLD: begin
        presc_nxt = '0;
        adv       = step_pulse;
        if (run_s) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Dropping run wins over a pending expiry: no tick, no advance.
        if (!run_s) begin
          state_nxt = ST_HOLD;
          presc_nxt = '0;
        end else if (presc == PW'(MAX_COUNT - 1)) begin
          presc_nxt = '0;
          expire    = 1'b1;
          adv       = 1'b1;
        end else begin
          presc_nxt = presc + PW'(1);
        end
      end
      default: state_nxt = ST_HOLD;
    endcase
  end

  assign adv_res = advance(digit, dir_s, LAST_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_HOLD;
      presc <= '0;
      digit <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      tick  <= expire;
      wrap  <= !load_s && adv && adv_res[DIGIT_W];
      if (load_s)   digit <= lv_clamp;
      else if (adv) digit <= adv_res[DIGIT_W-1:0];
    end
  end

endmodule
